// File: rtl/config_frame_loader.sv
// Configuration frame loader: shifts bitstream words into a bit-line frame,
// then strobes one word line per frame until the whole region is programmed.
module config_frame_loader #(
  parameter int BL_WIDTH = 514,
  parameter int WL_COUNT = 407,
  parameter int DATA_W   = 32,
  parameter int WL_PULSE = 2
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Start,
  input  logic [DATA_W-1:0]   i_Data,
  input  logic                i_Valid,
  output logic                o_Ready,
  output logic [BL_WIDTH-1:0] o_bl,
  output logic [WL_COUNT-1:0] o_wl,
  output logic                o_fabric_resetn,
  output logic                o_busy,
  output logic                o_done
);

  localparam int N  = (BL_WIDTH + DATA_W - 1) / DATA_W;
  localparam int WW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (WL_COUNT > 1) ? $clog2(WL_COUNT) : 1;
  localparam int PW = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PROG,
    GAP,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [WW-1:0]       word_q, word_d;
  logic [PW-1:0]       pulse_q, pulse_d;
  logic [BL_WIDTH-1:0] bl_q, bl_d;
  logic [WL_COUNT-1:0] wl_q, wl_d;
  logic                frst_q, frst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [BL_WIDTH-1:0] word_bits;
  logic [BL_WIDTH-1:0] word_sel;

  // Bits past BL_WIDTH in the last word have no slot here, so they drop out.
  for (genvar b = 0; b < BL_WIDTH; b++) begin : g_map
    assign word_bits[b] = i_Data[b % DATA_W];
    assign word_sel[b]  = (word_q == WW'(b / DATA_W));
  end

  assign o_Ready         = (state_q == SHIFT);
  assign o_bl            = bl_q;
  assign o_wl            = wl_q;
  assign o_fabric_resetn = frst_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    word_d  = word_q;
    pulse_d = pulse_q;
    bl_d    = bl_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (i_Start) begin
          state_d = SHIFT;
          row_d   = '0;
          word_d  = '0;
          bl_d    = '0;
        end
      end
      SHIFT: begin
        if (i_Valid) begin
          bl_d = (bl_q & ~word_sel) | (word_bits & word_sel);
          if (word_q == WW'(N - 1)) begin
            state_d = PROG;
            word_d  = '0;
            pulse_d = '0;
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end
      PROG: begin
        if (pulse_q == PW'(WL_PULSE - 1)) state_d = GAP;
        else pulse_d = pulse_q + PW'(1);
      end
      GAP: begin
        if (row_q == RW'(WL_COUNT - 1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
          row_d   = row_q + RW'(1);
          word_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered outputs are decoded from the next state.
    wl_d   = (state_d == PROG) ? (WL_COUNT'(1) << row_d) : '0;
    busy_d = (state_d == SHIFT) || (state_d == PROG) || (state_d == GAP);
    done_d = (state_d == DONE);
    frst_d = (state_d == DONE);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      word_q  <= '0;
      pulse_q <= '0;
      bl_q    <= '0;
      wl_q    <= '0;
      frst_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      word_q  <= word_d;
      pulse_q <= pulse_d;
      bl_q    <= bl_d;
      wl_q    <= wl_d;
      frst_q  <= frst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader: frames are scoreboarded on
// word-line strobes; a second narrow instance covers the partial last word.
module tb_config_frame_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, valid;
  logic [3:0] data;
  logic       ready, frst, busy, done;
  logic [7:0] bl;
  logic [2:0] wl;

  logic       start6, valid6;
  logic [3:0] data6;
  logic       ready6, frst6, busy6, done6;
  logic [5:0] bl6;
  logic [0:0] wl6;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;
  logic [10:0] exp_q[$];
  logic [3:0] w0s[3];
  logic [3:0] w1s[3];

  config_frame_loader #(
    .BL_WIDTH(8), .WL_COUNT(3), .DATA_W(4), .WL_PULSE(2)
  ) dut (
    .i_Clk(clk), .i_Reset(rst_n), .i_Start(start),
    .i_Data(data), .i_Valid(valid), .o_Ready(ready),
    .o_bl(bl), .o_wl(wl), .o_fabric_resetn(frst),
    .o_busy(busy), .o_done(done)
  );

  config_frame_loader #(
    .BL_WIDTH(6), .WL_COUNT(1), .DATA_W(4), .WL_PULSE(2)
  ) dut6 (
    .i_Clk(clk), .i_Reset(rst_n), .i_Start(start6),
    .i_Data(data6), .i_Valid(valid6), .o_Ready(ready6),
    .o_bl(bl6), .o_wl(wl6), .o_fabric_resetn(frst6),
    .o_busy(busy6), .o_done(done6)
  );

  task automatic tick;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load_row(input int row, input logic [3:0] w0,
                          input logic [3:0] w1, input int stall,
                          input bit pulse_start);
    logic [10:0] e;
    logic [10:0] f;
    e = {w1, w0, 3'b001 << row};
    f = 11'h7ff;
    start = pulse_start;
    valid = 1'b1;
    data = w0;
    chk("ready_shift", 32'(ready), 32'd1);
    if (row == 0) t0 = cyc + 1;
    tick;
    start = 1'b0;
    for (int s = 0; s < stall; s++) begin
      valid = 1'b0;
      data = 4'h9;
      tick;
      chk("stall_wl", 32'(wl), 32'd0);
      chk("stall_ready", 32'(ready), 32'd1);
    end
    valid = 1'b1;
    data = w1;
    exp_q.push_back(e);
    tick;
    valid = 1'b0;
    data = 4'h0;
    if (wl != 3'b000 && exp_q.size() != 0) begin
      f = exp_q.pop_front();
      chk("frame_p1", 32'({bl, wl}), 32'(f));
    end else begin
      chk("pulse_missing", 32'(wl), 32'(e[2:0]));
    end
    chk("prog_ready", 32'(ready), 32'd0);
    tick;
    chk("frame_p2", 32'({bl, wl}), 32'(e));
    tick;
    chk("gap", 32'({bl, wl}), 32'({e[10:3], 3'b000}));
    chk("gap_busy_frst", 32'({busy, frst}), 32'b10);
    tick;
  endtask

  task automatic full_load(input int stall, input bit pulse_start);
    for (int r = 0; r < 3; r++)
      load_row(r, w0s[r], w1s[r], stall, pulse_start);
    chk("done_flags", 32'({done, frst, busy, ready}), 32'b1100);
    chk("done_bl", 32'(bl), 32'h0f);
    chk("done_wl", 32'(wl), 32'd0);
    chk("load_cycles", 32'(cyc - t0 + 1), 32'(15 + 3 * stall));
  endtask

  initial begin
    w0s = '{4'hA, 4'h3, 4'hF};
    w1s = '{4'h5, 4'hC, 4'h0};
    rst_n = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    data = 4'h0;
    start6 = 1'b0;
    valid6 = 1'b0;
    data6 = 4'h0;
    tick;
    tick;
    chk("rst_outs", 32'({ready, bl, wl, frst, busy, done}), 32'd0);
    chk("rst_outs6", 32'({ready6, bl6, wl6, frst6, busy6, done6}), 32'd0);
    rst_n = 1'b1;
    tick;
    chk("idle", 32'({ready, busy, done, frst}), 32'd0);

    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start", 32'({busy, ready, bl}), 32'h300);
    full_load(0, 1'b0);

    start = 1'b1;
    tick;
    start = 1'b0;
    chk("restart", 32'({done, frst, busy, ready}), 32'b0011);
    chk("restart_bl", 32'(bl), 32'd0);
    full_load(3, 1'b1);

    start = 1'b1;
    tick;
    start = 1'b0;
    load_row(0, w0s[0], w1s[0], 0, 1'b0);
    valid = 1'b1;
    data = w0s[1];
    tick;
    data = w1s[1];
    tick;
    valid = 1'b0;
    chk("r1_prog", 32'(wl), 32'b010);
    rst_n = 1'b0;
    tick;
    chk("midrst", 32'({ready, bl, wl, frst, busy, done}), 32'd0);
    rst_n = 1'b1;
    tick;
    chk("midrst_idle", 32'({ready, busy}), 32'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    full_load(0, 1'b0);

    start6 = 1'b1;
    tick;
    start6 = 1'b0;
    valid6 = 1'b1;
    data6 = 4'h6;
    tick;
    data6 = 4'hF;
    tick;
    valid6 = 1'b0;
    chk("n6_p1", 32'({bl6, wl6}), 32'({6'h36, 1'b1}));
    chk("n6_top", 32'(bl6[5:4]), 32'b11);
    tick;
    chk("n6_p2", 32'({bl6, wl6}), 32'({6'h36, 1'b1}));
    tick;
    chk("n6_gap", 32'({bl6, wl6}), 32'({6'h36, 1'b0}));
    tick;
    chk("n6_done", 32'({done6, frst6, busy6, bl6}), 32'({3'b110, 6'h36}));

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
